// File: rtl/uart_rx_digit.sv
// uart_rx_digit
// -------------
// 8N1 UART receiver that turns ASCII hexadecimal characters into 4-bit digit
// values for the 7-segment display path. Each accepted digit is presented as a
// stable nibble plus a level-toggle strobe. The downstream shift stage waits for
// a toggle, delays, then captures the nibble. Non-hex bytes are reported on
// rx_byte/byte_valid but never move digit_data or digit_toggle.
//
// Parameters
//   CLK_HZ        system clock frequency in Hz
//   BAUD          serial bit rate
//   CLKS_PER_BIT  clocks per bit (CLK_HZ/BAUD by default, must be >= 16)
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   rx            asynchronous serial line, idle high
//   digit_data    last accepted digit value (0-15)
//   digit_toggle  inverts once per accepted digit
//   rx_byte       last byte received with a valid stop bit
//   byte_valid    one-cycle pulse when rx_byte updates
//   frame_err     one-cycle pulse when the stop bit samples low

module uart_rx_digit #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [3:0] digit_data,
    output logic       digit_toggle,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    // Mid-bit sampling needs a reasonable number of clocks per bit.
    generate
        if (CLKS_PER_BIT < 16) begin : g_cpb_check
            $error("uart_rx_digit: CLKS_PER_BIT must be >= 16");
        end
    endgenerate

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    // Returns {is_hex, value}. Uppercase and lowercase A-F share the low
    // nibble 1..6, so adding 9 gives 10..15.
    function automatic logic [4:0] hex_decode(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if ((b >= 8'h30) && (b <= 8'h39)) begin
            r = {1'b1, b[3:0]};
        end else if (((b >= 8'h41) && (b <= 8'h46)) ||
                     ((b >= 8'h61) && (b <= 8'h66))) begin
            r = {1'b1, b[3:0] + 4'd9};
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    logic             rx_meta_r;
    logic             rx_sync_r;
    logic             rx_prev_r;
    logic             start_edge_s;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       shift_r, shift_s;

    logic [3:0]       digit_r, digit_s;
    logic             toggle_r, toggle_s;
    logic [7:0]       byte_r, byte_s;
    logic             byte_valid_r, byte_valid_s;
    logic             frame_err_r, frame_err_s;
    logic [4:0]       dec_s;

    // Two-flop synchronizer plus one history flop for edge detection. All reset
    // to 0 so a line held low across reset release cannot look like a start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b0;
            rx_sync_r <= 1'b0;
            rx_prev_r <= 1'b0;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign start_edge_s = rx_prev_r & ~rx_sync_r;
    assign dec_s        = hex_decode(shift_r);

    // Next-state, datapath and output computation for the receive FSM.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        idx_s        = idx_r;
        shift_s      = shift_r;
        digit_s      = digit_r;
        toggle_s     = toggle_r;
        byte_s       = byte_r;
        byte_valid_s = 1'b0;
        frame_err_s  = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (start_edge_s) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end

            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (!rx_sync_r) begin
                        state_s = DATA;
                        idx_s   = 3'd0;
                    end else begin
                        // Line went high again before mid start bit: glitch.
                        state_s = IDLE;
                    end
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    shift_s = {rx_sync_r, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        idx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_s = {CNT_W{1'b0}};
                    if (rx_sync_r) begin
                        // Returning to IDLE at mid stop bit lets a back-to-back
                        // start edge half a bit later be caught.
                        state_s      = IDLE;
                        byte_s       = shift_r;
                        byte_valid_s = 1'b1;
                        if (dec_s[4]) begin
                            digit_s  = dec_s[3:0];
                            toggle_s = ~toggle_r;
                        end else begin
                            digit_s  = digit_r;
                            toggle_s = toggle_r;
                        end
                    end else begin
                        state_s     = WAIT_IDLE;
                        frame_err_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            WAIT_IDLE: begin
                // A break holds the line low; wait it out so it yields one error.
                cnt_s = {CNT_W{1'b0}};
                if (rx_sync_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_IDLE;
                end
            end

            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
                idx_s   = 3'd0;
            end
        endcase
    end

    // FSM state, bit timing counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= 3'd0;
            shift_r <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
        end
    end

    // Registered outputs; digit, toggle, byte and valid all move on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_r      <= 4'd0;
            toggle_r     <= 1'b0;
            byte_r       <= 8'd0;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            digit_r      <= digit_s;
            toggle_r     <= toggle_s;
            byte_r       <= byte_s;
            byte_valid_r <= byte_valid_s;
            frame_err_r  <= frame_err_s;
        end
    end

    assign digit_data   = digit_r;
    assign digit_toggle = toggle_r;
    assign rx_byte      = byte_r;
    assign byte_valid   = byte_valid_r;
    assign frame_err    = frame_err_r;

endmodule
